// File: rtl/dlsc_pcie_s6_outbound_arbiter.sv
// Round-robin arbiter sharing the PCIe transmit request path between the outbound
// write engine (header + payload) and the read engine (header only); whole TLPs only.
module dlsc_pcie_s6_outbound_arbiter #(
  parameter int ADDR = 32
) (
  input  logic            clk,
  input  logic            rst,

  output logic            wr_h_ready,
  input  logic            wr_h_valid,
  input  logic [ADDR-3:0] wr_h_addr,
  input  logic [9:0]      wr_h_len,
  input  logic [3:0]      wr_h_be_first,
  input  logic [3:0]      wr_h_be_last,

  output logic            wr_d_ready,
  input  logic            wr_d_valid,
  input  logic [31:0]     wr_d_data,

  output logic            rd_h_ready,
  input  logic            rd_h_valid,
  input  logic [ADDR-3:0] rd_h_addr,
  input  logic [9:0]      rd_h_len,
  input  logic [3:0]      rd_h_be_first,
  input  logic [3:0]      rd_h_be_last,

  input  logic            out_h_ready,
  output logic            out_h_valid,
  output logic            out_h_write,
  output logic [ADDR-3:0] out_h_addr,
  output logic [9:0]      out_h_len,
  output logic [3:0]      out_h_be_first,
  output logic [3:0]      out_h_be_last,

  input  logic            out_d_ready,
  output logic            out_d_valid,
  output logic [31:0]     out_d_data,
  output logic            out_d_last
);

  typedef enum logic {IDLE, DATA} state_t;

  state_t      state_reg, state_next;
  logic        last_grant_reg;
  logic [10:0] d_cnt_reg;
  logic        grant_wr, grant_rd, d_accept;

  always_comb begin
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    state_next = state_reg;
    // Ties go to whichever source was not served last (last_grant: 1 = read).
    if (!rst && state_reg == IDLE && (!out_h_valid || out_h_ready)) begin
      if (wr_h_valid && (!rd_h_valid || last_grant_reg))
        grant_wr = 1'b1;
      else if (rd_h_valid)
        grant_rd = 1'b1;
    end
    wr_d_ready = !rst && state_reg == DATA && (!out_d_valid || out_d_ready);
    d_accept   = wr_d_ready && wr_d_valid;
    if (grant_wr)
      state_next = DATA;
    else if (d_accept && d_cnt_reg == 11'd1)
      state_next = IDLE;
    wr_h_ready = grant_wr;
    rd_h_ready = grant_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      d_cnt_reg      <= 11'd0;
      out_h_valid    <= 1'b0;
      out_d_valid    <= 1'b0;
      out_d_last     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_wr || grant_rd) begin
        out_h_valid    <= 1'b1;
        last_grant_reg <= grant_rd;
      end else if (out_h_ready) begin
        out_h_valid <= 1'b0;
      end
      // A length of 0 means a full 1024-word payload.
      if (grant_wr)
        d_cnt_reg <= (wr_h_len == 10'd0) ? 11'd1024 : {1'b0, wr_h_len};
      else if (d_accept)
        d_cnt_reg <= d_cnt_reg - 11'd1;
      if (d_accept) begin
        out_d_valid <= 1'b1;
        out_d_last  <= (d_cnt_reg == 11'd1);
      end else if (out_d_ready) begin
        out_d_valid <= 1'b0;
      end
    end
  end

  // Header and payload contents need no reset; they are qualified by the valid flags.
  always_ff @(posedge clk) begin
    if (grant_wr) begin
      out_h_write    <= 1'b1;
      out_h_addr     <= wr_h_addr;
      out_h_len      <= wr_h_len;
      out_h_be_first <= wr_h_be_first;
      out_h_be_last  <= wr_h_be_last;
    end else if (grant_rd) begin
      out_h_write    <= 1'b0;
      out_h_addr     <= rd_h_addr;
      out_h_len      <= rd_h_len;
      out_h_be_first <= rd_h_be_first;
      out_h_be_last  <= rd_h_be_last;
    end
    if (d_accept)
      out_d_data <= wr_d_data;
  end

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_arbiter.sv
// Scoreboard bench for dlsc_pcie_s6_outbound_arbiter: queued sources, expected
// header/payload queues popped on output handshakes.
module tb_dlsc_pcie_s6_outbound_arbiter;
  localparam int ADDR = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            wr_h_ready, wr_h_valid;
  logic [ADDR-3:0] wr_h_addr;
  logic [9:0]      wr_h_len;
  logic [3:0]      wr_h_be_first, wr_h_be_last;
  logic            wr_d_ready, wr_d_valid;
  logic [31:0]     wr_d_data;
  logic            rd_h_ready, rd_h_valid;
  logic [ADDR-3:0] rd_h_addr;
  logic [9:0]      rd_h_len;
  logic [3:0]      rd_h_be_first, rd_h_be_last;
  logic            out_h_ready, out_h_valid, out_h_write;
  logic [ADDR-3:0] out_h_addr;
  logic [9:0]      out_h_len;
  logic [3:0]      out_h_be_first, out_h_be_last;
  logic            out_d_ready, out_d_valid, out_d_last;
  logic [31:0]     out_d_data;

  dlsc_pcie_s6_outbound_arbiter #(.ADDR(ADDR)) dut (
    .clk(clk), .rst(rst),
    .wr_h_ready(wr_h_ready), .wr_h_valid(wr_h_valid), .wr_h_addr(wr_h_addr),
    .wr_h_len(wr_h_len), .wr_h_be_first(wr_h_be_first), .wr_h_be_last(wr_h_be_last),
    .wr_d_ready(wr_d_ready), .wr_d_valid(wr_d_valid), .wr_d_data(wr_d_data),
    .rd_h_ready(rd_h_ready), .rd_h_valid(rd_h_valid), .rd_h_addr(rd_h_addr),
    .rd_h_len(rd_h_len), .rd_h_be_first(rd_h_be_first), .rd_h_be_last(rd_h_be_last),
    .out_h_ready(out_h_ready), .out_h_valid(out_h_valid), .out_h_write(out_h_write),
    .out_h_addr(out_h_addr), .out_h_len(out_h_len), .out_h_be_first(out_h_be_first),
    .out_h_be_last(out_h_be_last),
    .out_d_ready(out_d_ready), .out_d_valid(out_d_valid), .out_d_data(out_d_data),
    .out_d_last(out_d_last)
  );

  typedef struct packed {
    logic            write;
    logic [ADDR-3:0] addr;
    logic [9:0]      len;
    logic [3:0]      bf;
    logic [3:0]      bl;
  } hdr_t;
  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  hdr_t        wr_src[$], rd_src[$], exp_h[$];
  logic [31:0] wd_src[$];
  word_t       exp_d[$];
  int          total = 0, bad = 0, cycle = 0;
  bit          rand_bp = 1'b0;
  bit          wr_hs_s = 1'b0, rd_hs_s = 1'b0, wd_hs_s = 1'b0;
  bit          in_write = 1'b0, h_stall = 1'b0;
  int          words_left = 0, wd_count = 0;
  int          rd_grant_cyc[$], wd_cyc[$];
  hdr_t        held;

  // Source / sink driver: pops on handshakes seen at the previous falling edge
  initial begin
    wr_h_valid = 0; wr_h_addr = '0; wr_h_len = '0; wr_h_be_first = '0; wr_h_be_last = '0;
    rd_h_valid = 0; rd_h_addr = '0; rd_h_len = '0; rd_h_be_first = '0; rd_h_be_last = '0;
    wr_d_valid = 0; wr_d_data = '0; out_h_ready = 1; out_d_ready = 1;
    forever begin
      @(posedge clk);
      cycle++;
      #1;
      if (wr_hs_s) void'(wr_src.pop_front());
      if (rd_hs_s) void'(rd_src.pop_front());
      if (wd_hs_s) void'(wd_src.pop_front());
      wr_hs_s = 0; rd_hs_s = 0; wd_hs_s = 0;
      wr_h_valid = wr_src.size() > 0;
      if (wr_h_valid) begin
        wr_h_addr = wr_src[0].addr; wr_h_len = wr_src[0].len;
        wr_h_be_first = wr_src[0].bf; wr_h_be_last = wr_src[0].bl;
      end
      rd_h_valid = rd_src.size() > 0;
      if (rd_h_valid) begin
        rd_h_addr = rd_src[0].addr; rd_h_len = rd_src[0].len;
        rd_h_be_first = rd_src[0].bf; rd_h_be_last = rd_src[0].bl;
      end
      wr_d_valid = wd_src.size() > 0 && (!rand_bp || $urandom_range(0, 3) != 0);
      if (wd_src.size() > 0) wr_d_data = wd_src[0];
      out_h_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_d_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    hdr_t  cur, e;
    word_t ed;
    forever begin
      @(negedge clk);
      if (rst) continue;
      wr_hs_s = wr_h_valid && wr_h_ready;
      rd_hs_s = rd_h_valid && rd_h_ready;
      wd_hs_s = wr_d_valid && wr_d_ready;
      total++;
      if ((wr_h_ready || rd_h_ready) && (in_write || (wr_h_ready && rd_h_ready) || (out_h_valid && !out_h_ready))) begin
        bad++;
        $display("FAIL grant_excl: wr_h_ready=%0b rd_h_ready=%0b in_write=%0b expected no grant", wr_h_ready, rd_h_ready, in_write);
      end
      total++;
      if (wr_d_ready !== (in_write && (!out_d_valid || out_d_ready))) begin
        bad++;
        $display("FAIL wr_d_ready: got %0b expected %0b", wr_d_ready, in_write && (!out_d_valid || out_d_ready));
      end
      if (wd_hs_s) begin
        wd_count++; wd_cyc.push_back(cycle);
        words_left--;
        if (words_left <= 0) in_write = 0;
      end
      if (wr_hs_s) begin
        in_write = 1; words_left = (wr_h_len == 0) ? 1024 : int'(wr_h_len);
      end
      if (rd_hs_s) rd_grant_cyc.push_back(cycle);
      cur = {out_h_write, out_h_addr, out_h_len, out_h_be_first, out_h_be_last};
      if (h_stall) begin
        total++;
        if (!out_h_valid || cur !== held) begin
          bad++;
          $display("FAIL hdr_stable: got v=%0b %h expected v=1 %h", out_h_valid, cur, held);
        end
      end
      h_stall = out_h_valid && !out_h_ready;
      held = cur;
      if (out_h_valid && out_h_ready) begin
        total++;
        if (exp_h.size() == 0) begin
          bad++; $display("FAIL hdr_extra: got %h expected none", cur);
        end else begin
          e = exp_h.pop_front();
          if (cur !== e) begin
            bad++; $display("FAIL hdr: got %h expected %h", cur, e);
          end
        end
      end
      if (out_d_valid && out_d_ready) begin
        total++;
        if (exp_d.size() == 0) begin
          bad++; $display("FAIL data_extra: got %h last=%0b expected none", out_d_data, out_d_last);
        end else begin
          ed = exp_d.pop_front();
          if (out_d_data !== ed.data || out_d_last !== ed.last) begin
            bad++;
            $display("FAIL data: got %h last=%0b expected %h last=%0b", out_d_data, out_d_last, ed.data, ed.last);
          end
        end
      end
    end
  end

  task automatic mk_wr(input logic [9:0] len, output hdr_t h);
    int n = (len == 0) ? 1024 : int'(len);
    logic [31:0] w;
    h.write = 1'b1; h.addr = 30'($urandom); h.len = len;
    h.bf = 4'($urandom); h.bl = 4'($urandom);
    wr_src.push_back(h);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      wd_src.push_back(w);
      exp_d.push_back('{data: w, last: (i == n - 1)});
    end
  endtask

  task automatic mk_rd(input logic [9:0] len, output hdr_t h);
    h.write = 1'b0; h.addr = 30'($urandom); h.len = len;
    h.bf = 4'($urandom); h.bl = 4'($urandom);
    rd_src.push_back(h);
  endtask

  function automatic bit drained();
    return wr_src.size() == 0 && rd_src.size() == 0 && wd_src.size() == 0 &&
           exp_h.size() == 0 && exp_d.size() == 0 && !out_h_valid && !out_d_valid;
  endfunction

  task automatic wait_drain(input int limit);
    int n = 0;
    while (!drained() && n < limit) begin
      @(posedge clk); #2; n++;
    end
    total++;
    if (!drained()) begin
      bad++;
      $display("FAIL drain: got exp_h=%0d exp_d=%0d left after %0d cycles expected 0", exp_h.size(), exp_d.size(), n);
    end
  endtask

  task automatic flush();
    wr_src.delete(); rd_src.delete(); wd_src.delete(); exp_h.delete(); exp_d.delete();
    in_write = 0; words_left = 0; h_stall = 0;
  endtask

  task automatic test_reset();
    hdr_t h;
    rst = 1;
    mk_rd(10'd4, h); exp_h.push_back(h);
    repeat (3) begin
      @(negedge clk);
      total++;
      if (rd_h_ready !== 1'b0 || wr_h_ready !== 1'b0 || wr_d_ready !== 1'b0) begin
        bad++; $display("FAIL reset_ready: got rd=%0b wr=%0b d=%0b expected 0", rd_h_ready, wr_h_ready, wr_d_ready);
      end
    end
    total++;
    if (out_h_valid !== 1'b0 || out_d_valid !== 1'b0 || out_d_last !== 1'b0) begin
      bad++; $display("FAIL reset_out: got hv=%0b dv=%0b last=%0b expected 0", out_h_valid, out_d_valid, out_d_last);
    end
    @(posedge clk); #2; rst = 0;
    wait_drain(50);
    $display("test_reset done");
  endtask

  task automatic test_read_only();
    hdr_t h;
    @(posedge clk); #2;
    rd_grant_cyc.delete();
    mk_rd(10'd1, h); exp_h.push_back(h);
    mk_rd(10'd4, h); exp_h.push_back(h);
    mk_rd(10'd0, h); exp_h.push_back(h);
    wait_drain(50);
    total++;
    if (rd_grant_cyc.size() != 3 || rd_grant_cyc[1] - rd_grant_cyc[0] != 1 || rd_grant_cyc[2] - rd_grant_cyc[1] != 1) begin
      bad++; $display("FAIL read_b2b: got %0d grants expected 3 on consecutive cycles", rd_grant_cyc.size());
    end
    $display("test_read_only done");
  endtask

  task automatic test_both_after_reset();
    hdr_t hw, hr;
    @(posedge clk); #2; rst = 1;
    @(posedge clk); #2; rst = 0;
    wd_cyc.delete(); rd_grant_cyc.delete();
    mk_wr(10'd2, hw); mk_rd(10'd1, hr);
    exp_h.push_back(hw); exp_h.push_back(hr);
    wait_drain(50);
    total++;
    if (wd_cyc.size() != 2 || rd_grant_cyc.size() != 1 || rd_grant_cyc[0] != wd_cyc[1] + 1) begin
      bad++; $display("FAIL both_rd_timing: got words=%0d reads=%0d expected read grant one cycle after last word", wd_cyc.size(), rd_grant_cyc.size());
    end
    $display("test_both_after_reset done");
  endtask

  task automatic test_contention();
    hdr_t hw[4], hr[4];
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) begin
      mk_wr(10'd1, hw[i]); mk_rd(10'(i + 2), hr[i]);
    end
    for (int i = 0; i < 4; i++) begin
      exp_h.push_back(hw[i]); exp_h.push_back(hr[i]);
    end
    wait_drain(100);
    $display("test_contention done");
  endtask

  task automatic test_len0();
    hdr_t hw, hr;
    int c0;
    @(posedge clk); #2;
    c0 = wd_count;
    mk_wr(10'd0, hw); mk_rd(10'd7, hr);
    exp_h.push_back(hw); exp_h.push_back(hr);
    wait_drain(3000);
    total++;
    if (wd_count - c0 != 1024) begin
      bad++; $display("FAIL len0_words: got %0d expected 1024", wd_count - c0);
    end
    $display("test_len0 done");
  endtask

  task automatic test_random_bp();
    hdr_t hw[6], hr[4];
    int wi = 0, ri = 0;
    bit pref_wr = 1'b1;
    @(posedge clk); #2;
    rand_bp = 1;
    for (int i = 0; i < 6; i++) mk_wr(10'($urandom_range(1, 8)), hw[i]);
    for (int i = 0; i < 4; i++) mk_rd(10'($urandom_range(0, 1023)), hr[i]);
    while (wi < 6 || ri < 4) begin
      if (wi < 6 && (pref_wr || ri >= 4)) begin
        exp_h.push_back(hw[wi]); wi++; pref_wr = 0;
      end else begin
        exp_h.push_back(hr[ri]); ri++; pref_wr = 1;
      end
    end
    wait_drain(2000);
    rand_bp = 0;
    $display("test_random_bp done");
  endtask

  task automatic test_mid_reset();
    hdr_t hw, hr;
    int c0, n = 0;
    @(posedge clk); #2;
    c0 = wd_count;
    mk_wr(10'd8, hw); exp_h.push_back(hw);
    while (wd_count - c0 < 3 && n < 100) begin
      @(posedge clk); n++;
    end
    total++;
    if (wd_count - c0 < 3) begin
      bad++; $display("FAIL mid_wait: got %0d words expected 3", wd_count - c0);
    end
    #2; rst = 1; flush();
    @(posedge clk); #2; rst = 0;
    @(negedge clk);
    total++;
    if (out_h_valid !== 1'b0 || out_d_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset_out: got hv=%0b dv=%0b expected 0", out_h_valid, out_d_valid);
    end
    @(posedge clk); #2;
    mk_rd(10'd5, hr); exp_h.push_back(hr);
    wait_drain(50);
    $display("test_mid_reset done");
  endtask

  initial begin
    rst = 1;
    test_reset();
    test_read_only();
    test_both_after_reset();
    test_contention();
    test_len0();
    test_random_bp();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
